// File: rtl/shift_add_mul4.sv
// Sequential unsigned shift-add multiplier: one partial product per cycle through a
// WIDTH-bit ripple adder, 2*WIDTH-bit product after WIDTH iterations.

module shift_add_mul4_adder #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    logic [WIDTH:0] carry;

    assign carry[0] = cin;

    for (genvar i = 0; i < WIDTH; i++) begin : g_fa
        assign sum[i]       = x[i] ^ y[i] ^ carry[i];
        assign carry[i + 1] = (x[i] & y[i]) | (carry[i] & (x[i] ^ y[i]));
    end

    assign cout = carry[WIDTH];

endmodule

module shift_add_mul4 #(
    parameter int WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] p
);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    localparam int                CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0]  LAST  = CNT_W'(WIDTH - 1);

    state_t           state;
    state_t           next_state;
    logic [WIDTH-1:0] m;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] acc;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] addend;
    logic [WIDTH-1:0] sum;
    logic             c_out;
    logic             last_iter;

    assign addend    = q[0] ? m : '0;
    assign last_iter = (cnt == LAST);

    shift_add_mul4_adder #(
        .WIDTH(WIDTH)
    ) u_adder (
        .x   (acc),
        .y   (addend),
        .cin (1'b0),
        .sum (sum),
        .cout(c_out)
    );

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // NOTE: next_state gets a default before the case so no path infers a latch.
    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:    if (start) next_state = CALC;
            CALC:    if (last_iter) next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Status flags decode registered state only, so start never reaches them combinationally.
    always_comb begin
        busy = (state == CALC);
        done = (state == DONE);
    end

    // The carry-out lands in ACC's MSB, so the shifted partial product never loses a bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m   <= '0;
            q   <= '0;
            acc <= '0;
            cnt <= '0;
            p   <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        m   <= a;
                        q   <= b;
                        acc <= '0;
                        cnt <= '0;
                    end
                end
                CALC: begin
                    acc <= {c_out, sum[WIDTH-1:1]};
                    q   <= {sum[0], q[WIDTH-1:1]};
                    cnt <= cnt + CNT_W'(1);
                    if (last_iter) begin
                        p <= {c_out, sum[WIDTH-1:1], sum[0], q[WIDTH-1:1]};
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_shift_add_mul4.sv
// Directed bench for shift_add_mul4: vector table plus hand-written handshake,
// held-start and asynchronous-reset sequences.

module tb_shift_add_mul4;

    localparam int WIDTH = 4;

    logic               clk;
    logic               rst_n;
    logic               start;
    logic [WIDTH-1:0]   a;
    logic [WIDTH-1:0]   b;
    logic               busy;
    logic               done;
    logic [2*WIDTH-1:0] p;

    int total = 0;
    int bad   = 0;

    shift_add_mul4 #(
        .WIDTH(WIDTH)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .start(start),
        .a    (a),
        .b    (b),
        .busy (busy),
        .done (done),
        .p    (p)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [WIDTH-1:0]   va;
        logic [WIDTH-1:0]   vb;
        logic [2*WIDTH-1:0] vp;
        int                 mode;   // 1: re-assert start with new operands during CALC/DONE
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Runs one operation from a start pulse and observes 8 falling edges after the accepting edge.
    task automatic run_op(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                          input logic [2*WIDTH-1:0] exp, input int mode);
        int                 busy_n;
        int                 done_n;
        int                 done_at;
        logic [2*WIDTH-1:0] p_done;
        string              tag;
        tag = $sformatf("%0dx%0d", av, bv);
        @(negedge clk);
        a     = av;
        b     = bv;
        start = 1'b1;
        @(posedge clk);
        #1;
        start   = 1'b0;
        a       = ~av;
        b       = ~bv;
        busy_n  = 0;
        done_n  = 0;
        done_at = 0;
        p_done  = '0;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (busy) busy_n++;
            if (done) begin
                done_n++;
                done_at = i;
                p_done  = p;
            end
            if (mode == 1) begin
                if (i == 2) begin
                    start = 1'b1;
                    a     = 4'd2;
                    b     = 4'd2;
                end
                if (i == 3) begin
                    a = 4'd15;
                    b = 4'd15;
                end
                if (i == 6) start = 1'b0;
            end
        end
        check({tag, " busy cycles"}, busy_n, 4);
        check({tag, " done pulses"}, done_n, 1);
        check({tag, " done position"}, done_at, 5);
        check({tag, " p at done"}, p_done, exp);
        check({tag, " p holds"}, p, exp);
    endtask

    initial begin
        int done_n;
        rst_n = 1'b0;
        start = 1'b0;
        a     = '0;
        b     = '0;

        vecs[0] = '{4'd3,  4'd5,  8'd15,  0};
        vecs[1] = '{4'd15, 4'd15, 8'd225, 0};
        vecs[2] = '{4'd0,  4'd9,  8'd0,   0};
        vecs[3] = '{4'd9,  4'd0,  8'd0,   0};
        vecs[4] = '{4'd7,  4'd6,  8'd42,  1};
        vecs[5] = '{4'd15, 4'd1,  8'd15,  0};

        repeat (3) @(negedge clk);
        check("reset busy", busy, 0);
        check("reset done", done, 0);
        check("reset p", p, 0);
        rst_n = 1'b1;

        for (int i = 0; i < 6; i++) begin
            run_op(vecs[i].va, vecs[i].vb, vecs[i].vp, vecs[i].mode);
        end

        // start held high: completions every WIDTH+2 cycles
        @(negedge clk);
        a      = 4'd10;
        b      = 4'd11;
        start  = 1'b1;
        @(posedge clk);
        #1;
        done_n = 0;
        for (int i = 1; i <= 18; i++) begin
            @(negedge clk);
            if (done) begin
                check("held start done position", i, 5 + 6 * done_n);
                check("held start p", p, 110);
                done_n++;
            end
            if (i == 18) start = 1'b0;
        end
        check("held start done count", done_n, 3);
        repeat (3) @(negedge clk);
        check("held start idle after drop", busy, 0);

        // asynchronous reset in CALC cycle 2
        @(negedge clk);
        a     = 4'd13;
        b     = 4'd12;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("busy before abort", busy, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort busy", busy, 0);
        check("abort done", done, 0);
        check("abort p", p, 0);
        repeat (2) @(negedge clk);
        rst_n  = 1'b1;
        done_n = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done) done_n++;
        end
        check("no done after abort", done_n, 0);
        check("p stays 0 after abort", p, 0);

        run_op(4'd2, 4'd3, 8'd6, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
